flash_field_pattern_gen: RTL
============================

Name: flash_field_pattern_gen

Overview:
- Parametrised successor to the lag-test video generator.
- Paints NUM_FIELDS flashing white rectangles whose on/off state toggles every period_frames frames, and pulses starttrigger when the fields turn on so the photodiode/lag measurement can start.
- Overlays one bitmap text window (resolution/lag text rows supplied by an external font ROM).
- Sits between the video timing generator and the HDMI/DVI encoder. Output is pipelined with a valid flag.

Parameters:
- NUM_FIELDS, 3, number of flashing rectangles (1..8)
- DATA_WIDTH, 24, pixel width (RGB888)
- TEXT_WIDTH, 192, bits per text bitmap row
- TEXT_HEIGHT, 16, glyph rows in the text window before vertical scaling

Ports:
- clock  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse from timing generator at first active line start
- de  in  1  display enable for current pixel
- visible_counterX  in  12  active-area x
- visible_counterY  in  12  active-area y
- flash_enable  in  1  sampled only on frame_start
- period_frames  in  8  flash half-period in frames, sampled on frame_start; 0 is treated as 1
- field_rects  in  NUM_FIELDS*48  per field {x0,x1,y0,y1}, 12 bits each; field 0 in LSBs; half-open [x0,x1)×[y0,y1)
- text_x0, text_y0  in  12 each  text window origin
- text_h_div, text_v_div  in  2 each  text scale shift (pixel = glyph bit << div)
- text_line  in  TEXT_WIDTH  bitmap row for current y; MSB = leftmost
- field_on  out  1  current flash state
- starttrigger  out  1  one-cycle pulse on off→on transition
- data  out  DATA_WIDTH  pixel
- data_valid  out  1  de delayed to match data

Behaviour:
- Reset: all outputs 0; frame counter 0; field_on 0; pipeline cleared.
- Frame counter (8-bit), updated only on frame_start:
  - flash_enable low: counter 0, field_on 0, no trigger.
  - flash_enable high, counter < P-1 (P = max(period_frames, 1)): counter increments.
  - Otherwise the counter wraps to 0 and field_on toggles. If P is lowered below the current count, the counter wraps on the next frame_start.
- starttrigger: high exactly one cycle, in the cycle after the frame_start that sets field_on 0→1. It is 0 at all other times, including the on→off transition.
- Pixel pipeline, 2-cycle latency from visible_counterX/Y/de/text_line to data/data_valid:
  - Stage 1: per-field rectangle hit; text window hit; text bit index = TEXT_WIDTH-1 - ((x - text_x0) >> text_h_div), registered.
  - Stage 2: colour mux.
- Text window:
  - x in [text_x0, text_x0 + (TEXT_WIDTH << text_h_div))
  - y in [text_y0, text_y0 + (TEXT_HEIGHT << text_v_div))
  - Width arithmetic is done at 14 bits, with no 12-bit wrap.
- Colour priority: de low → 0; field_on && any field hit → all ones; text hit → text bit ? all ones : 0; else 0.
- A rect with x0>=x1 or y0>=y1 never hits.
- field_on used by the pipeline is the registered value, so a flash change takes effect from the first pixel after frame_start.
- Reset asserted mid-frame clears state immediately. After release, nothing flashes until the next frame_start with flash_enable high.

Optional Feature:
- Macro: FLASH_FIELD_FRAME_STAMP_EN.
- Defined:
  - A 16-bit frame_seq counter increments on every frame_start (reset 0, wraps at 0xFFFF→0).
  - On visible line y==0, pixels x=0..15 show frame_seq bit (15-x) as all ones/0, overriding all other content, with the same 2-cycle latency.
- Undefined: no frame_seq logic; line 0 renders normally.

Decomposition:
- Package videogen_pkg holds:
  - rect_t typedef {x0,x1,y0,y1} of 12-bit fields
  - COLOR_WHITE / COLOR_BLACK constants
  - RECT_BITS = 48
- One sub-module, rect_hit: combinational half-open rectangle compare, instantiated NUM_FIELDS times via generate.

Test Plan:
- Period and trigger: flash_enable=1, period_frames=4, 12 frame_start pulses.
  - field_on toggles after pulses 4, 8, 12.
  - starttrigger pulses once, one cycle after pulse 4 and after pulse 12.
- Period 0: period_frames=0 → field_on toggles on every frame_start.
- Disable mid-flash: drop flash_enable while field_on=1 → at next frame_start field_on=0, counter 0, no trigger.
- Field render: field0 = {100,200,50,60}, field_on=1, x=199,y=59 → data=FFFFFF two cycles later; x=200 → 0; with x0=x1=100 → never FFFFFF.
- Text and latency:
  - text_x0=8, h_div=1, text_line MSB=1, x=8 and x=9 → FFFFFF; x=7 → 0.
  - de=0 → data=0, data_valid=0 two cycles later.
- Frame stamp (macro defined): after 5 frame_start pulses, line 0 pixels 13 and 15 → FFFFFF, pixel 14 → 0; undefined → normal content.

Source files
------------

// File: rtl/videogen_pkg.sv
// Shared types and constants for the flash-field pattern generator.
package videogen_pkg;

  // One rectangle occupies 48 bits in the packed field_rects bus.
  localparam int RECT_BITS = 48;

  // Half-open rectangle [x0,x1) x [y0,y1); x0 sits in the MSBs.
  typedef struct packed {
    logic [11:0] x0;
    logic [11:0] x1;
    logic [11:0] y0;
    logic [11:0] y1;
  } rect_t;

  // Per-bit colour values, replicated to the pixel width by the user.
  localparam logic COLOR_WHITE = 1'b1;
  localparam logic COLOR_BLACK = 1'b0;

endpackage

// File: rtl/flash_field_pattern_gen_rect_hit.sv
// Combinational half-open rectangle compare. A rectangle with x0>=x1 or
// y0>=y1 can never satisfy both bounds, so it never hits.
module rect_hit
  import videogen_pkg::*;
(
  input  rect_t       rect,
  input  logic [11:0] x,
  input  logic [11:0] y,
  output logic        hit
);

  // Pixel lies inside the rectangle on both axes.
  always_comb begin
    hit = (x >= rect.x0) && (x < rect.x1) && (y >= rect.y0) && (y < rect.y1);
  end

endmodule

// File: rtl/flash_field_pattern_gen.sv
// Flashing-field lag-test pattern generator with a bitmap text overlay.
// Optional build macro FLASH_FIELD_FRAME_STAMP_EN adds a 16-bit frame
// sequence stamp drawn on line 0, pixels 0..15.
// frame_count exposes the flash frame counter for debug.
module flash_field_pattern_gen
  import videogen_pkg::*;
#(
  parameter int NUM_FIELDS  = 3,
  parameter int DATA_WIDTH  = 24,
  parameter int TEXT_WIDTH  = 192,
  parameter int TEXT_HEIGHT = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic                          de,
  input  logic [11:0]                   visible_counterX,
  input  logic [11:0]                   visible_counterY,
  input  logic                          flash_enable,
  input  logic [7:0]                    period_frames,
  input  logic [NUM_FIELDS*RECT_BITS-1:0] field_rects,
  input  logic [11:0]                   text_x0,
  input  logic [11:0]                   text_y0,
  input  logic [1:0]                    text_h_div,
  input  logic [1:0]                    text_v_div,
  input  logic [TEXT_WIDTH-1:0]         text_line,
  output logic                          field_on,
  output logic                          starttrigger,
  output logic [DATA_WIDTH-1:0]         data,
  output logic                          data_valid,
  output logic [7:0]                    frame_count
);

  localparam int IW = $clog2(TEXT_WIDTH);

  // Handshake note: there is no back-pressure. data_valid is de delayed by
  // exactly two clocks and qualifies data in the same cycle.

  logic [7:0] period_last;
  assign period_last = (period_frames == 8'd0) ? 8'd0 : (period_frames - 8'd1);

  // Flash state machine: counter and on/off state advance only on frame_start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_count  <= 8'd0;
      field_on     <= 1'b0;
      starttrigger <= 1'b0;
    end else begin
      starttrigger <= 1'b0;
      if (frame_start) begin
        if (!flash_enable) begin
          frame_count <= 8'd0;
          field_on    <= 1'b0;
        end else if (frame_count < period_last) begin
          frame_count <= frame_count + 8'd1;
        end else begin
          frame_count  <= 8'd0;
          field_on     <= ~field_on;
          starttrigger <= ~field_on;
        end
      end
    end
  end

  // Per-field rectangle hits.
  logic [NUM_FIELDS-1:0] hits;
  for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_field
    rect_t r;
    assign r = rect_t'(field_rects[g*RECT_BITS +: RECT_BITS]);
    rect_hit u_hit (.rect(r), .x(visible_counterX), .y(visible_counterY), .hit(hits[g]));
  end

  // Text window bounds at 14 bits so a window near the right edge never wraps.
  logic [13:0] x14, y14, tx0, ty0, tw, th, dx, scaled;
  logic        text_hit_c, text_bit_c;
  logic [IW-1:0] text_idx;
  assign x14    = {2'b00, visible_counterX};
  assign y14    = {2'b00, visible_counterY};
  assign tx0    = {2'b00, text_x0};
  assign ty0    = {2'b00, text_y0};
  assign tw     = 14'(TEXT_WIDTH) << text_h_div;
  assign th     = 14'(TEXT_HEIGHT) << text_v_div;
  assign dx     = x14 - tx0;
  assign scaled = dx >> text_h_div;
  assign text_idx = IW'(14'(TEXT_WIDTH - 1) - scaled);

  // Window test and glyph bit select; the bit is only meaningful inside.
  always_comb begin
    text_hit_c = (x14 >= tx0) && (x14 < tx0 + tw) && (y14 >= ty0) && (y14 < ty0 + th);
    text_bit_c = 1'b0;
    if (text_hit_c) text_bit_c = text_line[text_idx];
  end

`ifdef FLASH_FIELD_FRAME_STAMP_EN
  logic [15:0] frame_seq;
  logic        stamp1, stamp_bit1;

  // Free-running frame sequence number, counts every frame_start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) frame_seq <= 16'd0;
    else if (frame_start) frame_seq <= frame_seq + 16'd1;
  end

  // Stamp stage 1: line 0, pixels 0..15 show frame_seq MSB first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stamp1     <= 1'b0;
      stamp_bit1 <= 1'b0;
    end else begin
      stamp1     <= (visible_counterY == 12'd0) && (visible_counterX < 12'd16);
      stamp_bit1 <= frame_seq[4'd15 - visible_counterX[3:0]];
    end
  end
`endif

  logic de1, field_hit1, text_hit1, text_bit1;

  // Pipeline stage 1: register hit flags and the selected glyph bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      de1        <= 1'b0;
      field_hit1 <= 1'b0;
      text_hit1  <= 1'b0;
      text_bit1  <= 1'b0;
    end else begin
      de1        <= de;
      field_hit1 <= |hits;
      text_hit1  <= text_hit_c;
      text_bit1  <= text_bit_c;
    end
  end

  // Pipeline stage 2: colour priority mux using the registered flash state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data       <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= de1;
      if (!de1) begin
        data <= {DATA_WIDTH{COLOR_BLACK}};
`ifdef FLASH_FIELD_FRAME_STAMP_EN
      end else if (stamp1) begin
        data <= {DATA_WIDTH{stamp_bit1}};
`endif
      end else if (field_on && field_hit1) begin
        data <= {DATA_WIDTH{COLOR_WHITE}};
      end else if (text_hit1) begin
        data <= text_bit1 ? {DATA_WIDTH{COLOR_WHITE}} : {DATA_WIDTH{COLOR_BLACK}};
      end else begin
        data <= {DATA_WIDTH{COLOR_BLACK}};
      end
    end
  end

endmodule
